// File: rtl/core_pkg.sv
// core_pkg: shared FSM state, opcode and PC-source encodings for the sequencer.
package core_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} seq_state_e;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_IMM    = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;
    localparam logic [1:0] PC_TRAP   = 2'd3;
    typedef struct packed {
        logic legal;
        logic mem;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
    } op_class_t;
endpackage

// File: rtl/core_seq_ctrl_if.sv
// core_seq_ctrl_if: instruction/data memory request-acknowledge handshake.
interface core_seq_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;
    modport master (output imem_req, dmem_req, dmem_we, input imem_ack, dmem_ack);
    modport slave (input imem_req, dmem_req, dmem_we, output imem_ack, dmem_ack);
endinterface

// File: rtl/opcode_class.sv
// opcode_class: combinational opcode legality and class decode; X/Z matches no legal item.
module opcode_class
    import core_pkg::*;
(
    input  logic [6:0] i_opcode,
    output op_class_t  o_cls
);
    always_comb begin
        o_cls = '0;
        case (i_opcode)
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: o_cls.legal = 1'b1;
            OP_JAL: begin
                o_cls.legal = 1'b1;
                o_cls.jal = 1'b1;
            end
            OP_JALR: begin
                o_cls.legal = 1'b1;
                o_cls.jalr = 1'b1;
            end
            OP_BRANCH: begin
                o_cls.legal = 1'b1;
                o_cls.branch = 1'b1;
            end
            OP_LOAD: begin
                o_cls.legal = 1'b1;
                o_cls.mem = 1'b1;
            end
            OP_STORE: begin
                o_cls.legal = 1'b1;
                o_cls.mem = 1'b1;
                o_cls.store = 1'b1;
            end
            default: o_cls = '0;
        endcase
    end
endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer with retire counter.
// Define SEQ_CTRL_TRAP_EN to route illegal opcodes to a one-cycle TRAP state instead of a NOP.
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    core_seq_ctrl_if.master  mem,
    input  logic [6:0]       i_opcode,
    input  logic             i_br_taken,
    output logic             o_ir_we,
    output logic             o_rf_we,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic             o_retire,
    output logic [RET_W-1:0] o_ret_cnt,
    output logic             o_trap
);
`ifdef SEQ_CTRL_TRAP_EN
    localparam seq_state_e ILLEGAL_NEXT = S_TRAP;
`else
    localparam seq_state_e ILLEGAL_NEXT = S_WB;
`endif
    seq_state_e       r_state, w_next;
    op_class_t        r_cls, w_cls;
    logic             r_taken;
    logic             r_run;
    logic [RET_W-1:0] r_ret_cnt;
    opcode_class u_opcode_class (.i_opcode(i_opcode), .o_cls(w_cls));
    // r_run keeps the fetch request low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_cls     <= '0;
            r_taken   <= 1'b0;
            r_run     <= 1'b0;
            r_ret_cnt <= '0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (r_state == S_DECODE) r_cls <= w_cls;
            if (r_state == S_EXEC) r_taken <= i_br_taken;
            if (o_retire) r_ret_cnt <= r_ret_cnt + 1'b1;
        end
    end
    always_comb begin
        w_next       = r_state;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        o_ir_we      = 1'b0;
        o_rf_we      = 1'b0;
        o_pc_we      = 1'b0;
        o_pc_sel     = PC_PLUS4;
        o_retire     = 1'b0;
        o_trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem.imem_req = r_run;
                o_ir_we      = r_run && mem.imem_ack;
                w_next       = (r_run && mem.imem_ack) ? S_DECODE : S_FETCH;
            end
            S_DECODE: w_next = w_cls.legal ? S_EXEC : ILLEGAL_NEXT;
            S_EXEC: w_next = r_cls.mem ? S_MEM : S_WB;
            S_MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = r_cls.store;
                w_next       = mem.dmem_ack ? S_WB : S_MEM;
            end
            S_WB: begin
                o_pc_we  = 1'b1;
                o_retire = 1'b1;
                o_rf_we  = r_cls.legal && !r_cls.branch && !r_cls.store;
                o_pc_sel = r_cls.jal ? PC_IMM : r_cls.jalr ? PC_JALR :
                           (r_cls.branch && r_taken) ? PC_IMM : PC_PLUS4;
                w_next   = S_FETCH;
            end
`ifdef SEQ_CTRL_TRAP_EN
            S_TRAP: begin
                o_pc_we  = 1'b1;
                o_pc_sel = PC_TRAP;
                o_trap   = 1'b1;
                w_next   = S_FETCH;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end
    assign o_ret_cnt = r_ret_cnt;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed scoreboard bench; expectations queued per instruction, checked at retire/trap.
module tb_core_seq_ctrl;
    import core_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    core_seq_ctrl_if bus ();
    logic [6:0] opcode = OP_REG;
    logic       br_taken = 1'b0;
    logic       ir_we, rf_we, pc_we, retire, trap;
    logic [1:0] pc_sel;
    logic [3:0] ret_cnt;
    core_seq_ctrl #(.RET_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem(bus), .i_opcode(opcode), .i_br_taken(br_taken),
        .o_ir_we(ir_we), .o_rf_we(rf_we), .o_pc_we(pc_we), .o_pc_sel(pc_sel),
        .o_retire(retire), .o_ret_cnt(ret_cnt), .o_trap(trap)
    );
    typedef struct {
        string      tag;
        int         cyc;
        logic       rf;
        logic [1:0] sel;
        logic       dwe;
        int         dc;
        logic       ret;
        logic       trp;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int i_dly = 0, d_dly = 0, ik = 0, dk = 0;
    logic d_spur = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // memory responders; imem_ack idles high so stray acks outside FETCH are exercised
    always @(negedge clk) begin
        if (bus.imem_req) begin
            bus.imem_ack = (ik == i_dly);
            ik++;
        end else begin
            bus.imem_ack = 1'b1;
            ik = 0;
        end
        if (bus.dmem_req) begin
            bus.dmem_ack = (dk == d_dly);
            dk++;
        end else begin
            bus.dmem_ack = d_spur;
            dk = 0;
        end
    end
    logic       in_ins = 1'b0;
    int         cnt = 0, dc = 0;
    logic       dwe = 1'b0;
    logic [3:0] exp_cnt = 4'd0;
    exp_t       e;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ins = 1'b0;
            exp_cnt = 4'd0;
        end else begin
            if (bus.imem_req && bus.dmem_req) chk("one_req", 32'd1, 32'd0);
            if (!in_ins && bus.imem_req) begin
                in_ins = 1'b1;
                cnt = 0;
                dc = 0;
                dwe = 1'b0;
            end
            if (in_ins) begin
                cnt++;
                if (bus.dmem_req) begin
                    dc++;
                    dwe = dwe | bus.dmem_we;
                end
                if (retire || trap) begin
                    checks++;
                    assert (sb.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_completion observed=%0d expected=%0d", 0, 1);
                    end
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk({e.tag, ".cycles"}, cnt, e.cyc);
                        chk({e.tag, ".rf_we"}, rf_we, e.rf);
                        chk({e.tag, ".pc_sel"}, pc_sel, e.sel);
                        chk({e.tag, ".pc_we"}, pc_we, 1);
                        chk({e.tag, ".retire"}, retire, e.ret);
                        chk({e.tag, ".trap"}, trap, e.trp);
                        chk({e.tag, ".dmem_cycles"}, dc, e.dc);
                        chk({e.tag, ".dmem_we"}, dwe, e.dwe);
                        chk({e.tag, ".ret_cnt"}, ret_cnt, exp_cnt);
                        if (e.ret) exp_cnt++;
                    end
                    in_ins = 1'b0;
                end
            end
        end
    end
    task automatic run(input string tag, input logic [6:0] op, input logic br, input int idl,
                       input int ddl, input int cyc, input logic rf, input logic [1:0] sel,
                       input logic xdwe, input int xdc, input logic ret, input logic trp);
        exp_t x;
        bit seen = 1'b0;
        x.tag = tag; x.cyc = cyc; x.rf = rf; x.sel = sel;
        x.dwe = xdwe; x.dc = xdc; x.ret = ret; x.trp = trp;
        sb.push_back(x);
        opcode = op;
        br_taken = br;
        i_dly = idl;
        d_dly = ddl;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = retire || trap;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s.timeout observed=%0d expected=%0d", tag, 0, 1);
        end
    endtask
    initial begin
        bit seen = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_ret_cnt", ret_cnt, 0);
        chk("rst_retire", retire, 0);
        rst_n = 1'b1;
        #1 chk("rel_imem_req_before_edge", bus.imem_req, 0);
        @(posedge clk);
        #1 chk("rel_imem_req_first_edge", bus.imem_req, 1);
        run("add", OP_REG, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0);
        @(posedge clk);
        #1 chk("add_ret_cnt", ret_cnt, 1);
        run("bne_taken", OP_BRANCH, 1, 0, 0, 4, 0, 2'd1, 0, 0, 1, 0);
        run("bne_not_taken", OP_BRANCH, 0, 0, 0, 4, 0, 2'd0, 0, 0, 1, 0);
        run("jal", OP_JAL, 0, 0, 0, 4, 1, 2'd1, 0, 0, 1, 0);
        run("jalr", OP_JALR, 0, 0, 0, 4, 1, 2'd2, 0, 0, 1, 0);
        run("lui", OP_LUI, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0);
        run("auipc", OP_AUIPC, 1, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0);
        run("addi", OP_IMM, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0);
        run("load_wait3", OP_LOAD, 0, 0, 3, 8, 1, 2'd0, 0, 4, 1, 0);
        run("store", OP_STORE, 0, 0, 0, 5, 0, 2'd0, 1, 1, 1, 0);
        run("add_iwait2", OP_REG, 0, 2, 0, 6, 1, 2'd0, 0, 0, 1, 0);
        d_spur = 1'b1;
        run("add_stray_dack", OP_REG, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0);
        d_spur = 1'b0;
`ifdef SEQ_CTRL_TRAP_EN
        run("illegal_trap", 7'h7f, 0, 0, 0, 3, 0, 2'd3, 0, 0, 0, 1);
`else
        run("illegal_nop", 7'h7f, 0, 0, 0, 3, 0, 2'd0, 0, 0, 1, 0);
`endif
        run("after_illegal", OP_REG, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0);
        opcode = OP_LOAD;
        d_dly = 20;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = bus.dmem_req;
        end
        chk("mem_reached", seen, 1);
        #1 rst_n = 1'b0;
        #1 chk("arst_dmem_req", bus.dmem_req, 0);
        chk("arst_imem_req", bus.imem_req, 0);
        chk("arst_strobes", {ir_we, rf_we, pc_we, retire, trap, pc_sel}, 0);
        chk("arst_ret_cnt", ret_cnt, 0);
        #1 rst_n = 1'b1;
        #1 chk("arst_rel_imem_req", bus.imem_req, 0);
        @(posedge clk);
        #1 chk("arst_refetch", bus.imem_req, 1);
        for (int i = 0; i < 16; i++) run("wrap_add", OP_REG, 0, 0, 0, 4, 1, 2'd0, 0, 0, 1, 0);
        @(posedge clk);
        #1 chk("ret_cnt_wrap", ret_cnt, 0);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 Parameter RET_W, default 32: width of the retired-instruction counter.
REQ-002 clk  in  1  core clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 opcode  in  7  inst[6:0] from decode; sampled only in DECODE.
REQ-005 br_taken  in  1  branch comparison result from the ALU; sampled only in EXEC.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_ack  in  1  instruction memory reply; data is valid in the same cycle.
REQ-008 dmem_req  out  1  data memory request.
REQ-009 dmem_we  out  1  store qualifier for dmem_req.
REQ-010 dmem_ack  in  1  data memory completion.
REQ-011 ir_we  out  1  instruction register load strobe.
REQ-012 rf_we  out  1  register-file write strobe.
REQ-013 pc_we  out  1  PC update strobe.
REQ-014 pc_sel  out  2  PC source: 0 = pc+4, 1 = pc+imm, 2 = rs1+imm (JALR), 3 = trap vector.
REQ-015 retire  out  1  one-cycle pulse per completed instruction.
REQ-016 ret_cnt  out  RET_W  retired-instruction count.
REQ-017 trap  out  1  high while in the TRAP state (SEQ_CTRL_TRAP_EN builds only; tied 0 otherwise).

Function
REQ-018 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP, and SHALL enter FETCH on reset.
REQ-019 FETCH: imem_req is held high until imem_ack. On ack, ir_we pulses in the same cycle and the next state is DECODE.
REQ-020 DECODE SHALL last one cycle. Legal opcodes are 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011 and 0110011; a legal opcode goes to EXEC.
REQ-021 EXEC SHALL last one cycle. LOAD (0000011) and STORE (0100011) go to MEM; all others go to WB.
REQ-022 MEM: dmem_req is held high, with dmem_we=1 for STORE, until dmem_ack; on ack the next state is WB.
REQ-023 WB SHALL last one cycle with pc_we=1 and retire=1, and the next state is FETCH.
REQ-024 In WB, rf_we=1 for all opcodes except BRANCH (1100011) and STORE.
REQ-025 pc_sel in WB:
- JAL: 1.
- JALR: 2.
- BRANCH: 1 if br_taken was sampled 1 in EXEC, else 0.
- all other opcodes: 0.
REQ-026 Latency with zero-wait ack: non-memory instructions take 4 cycles from FETCH entry to WB exit; LOAD/STORE take 5. Each extra ack-wait cycle adds 1.
REQ-027 ret_cnt SHALL increment on every retire pulse and wrap from 2^RET_W-1 to 0.
REQ-028 All strobe outputs SHALL be 0 in every state except where stated above; at most one of imem_req and dmem_req is high in any cycle.
REQ-029 An imem_ack outside FETCH or a dmem_ack outside MEM SHALL be ignored.
REQ-030 An X or Z opcode in DECODE SHALL be treated as illegal.

Reset
REQ-031 rst_n low SHALL force, immediately and asynchronously, state=FETCH, ret_cnt=0 and all outputs 0 (including imem_req). This holds mid-transaction, including during MEM.
REQ-032 After rst_n rises, imem_req SHALL assert on the first rising edge.

Configuration
REQ-033 With SEQ_CTRL_TRAP_EN defined, an illegal opcode in DECODE SHALL go to TRAP.
- TRAP lasts one cycle with pc_we=1, pc_sel=3, trap=1 and retire=0, then goes to FETCH.
REQ-034 Without SEQ_CTRL_TRAP_EN, an illegal opcode SHALL go directly to WB and be treated as a NOP: rf_we=0, pc_sel=0, retire=1. The TRAP state and pc_sel=3 SHALL be unreachable.

Structure
REQ-035 The shared package core_pkg SHALL hold:
- the state enum seq_state_e;
- the opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG);
- the pc_sel encodings.
REQ-036 The opcode-legality and class decode SHALL be a sub-module named opcode_class, purely combinational.
REQ-037 The FSM, strobes and counter SHALL reside in core_seq_ctrl.

Verification
REQ-038 Stimulus: ADD 32'h002081b3, imem_ack tied 1. Required: 4-cycle sequence; rf_we=1, pc_sel=0 in WB; ret_cnt=1.
REQ-039 Stimulus: BNE 32'hfe111ce3 with br_taken=1, then again with br_taken=0. Required: rf_we=0 and pc_sel=1, then pc_sel=0.
REQ-040 Stimulus: JAL 32'hff9ff26f. Required: rf_we=1 and pc_sel=1 in WB.
REQ-041 Stimulus: LOAD with dmem_ack delayed 3 cycles. Required: dmem_req high exactly 4 cycles, dmem_we=0, total 8 cycles; STORE gives dmem_we=1 and rf_we=0.
REQ-042 Stimulus: opcode 32'h0000007f. Required: with SEQ_CTRL_TRAP_EN, trap=1 and pc_sel=3 for 1 cycle with ret_cnt unchanged; without it, retire=1 and rf_we=0.
REQ-043 Stimulus: rst_n pulsed low mid-MEM, plus RET_W=4 run for 16 instructions. Required: outputs 0 asynchronously and FETCH re-entered; ret_cnt wraps to 0.
